// File: rtl/csr_counters.sv
// rtl/csr_counters.sv - machine counter CSRs: mcycle, minstret, HPM counters, inhibit, ID registers
//
// Ports:
//   clock, reset_n    - rising-edge clock, asynchronous active-low reset
//   csr_en, csr_op    - CSR access strobe; op 01 RW, 10 RS, 11 RC, 00 read-only
//   addr, wdata       - CSR address and write operand
//   retire, events    - per-cycle retire pulse and performance event pulses
//   rdata, illegal    - combinational read data and illegal-access flag

module csr_counters #(
    parameter int          XLEN       = 32,
    parameter int          NUM_HPM    = 4,
    parameter int          NUM_EVENTS = 8,
    parameter logic [31:0] MISA       = 32'h4000_0010,
    parameter logic [31:0] MVENDORID  = "beka",
    parameter logic [31:0] MARCHID    = 32'h0531_8008
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  csr_en,
    input  logic [1:0]            csr_op,
    input  logic [11:0]           addr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  retire,
    input  logic [NUM_EVENTS-1:0] events,
    output logic [XLEN-1:0]       rdata,
    output logic                  illegal
);

    // Arrays keep at least one entry so NUM_HPM = 0 still elaborates.
    localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;

    // Writable inhibit bits: mcycle (0), minstret (2) and one per implemented HPM counter.
    localparam logic [31:0] INH_MASK =
        32'h0000_0005 | 32'((((64'd1 << NUM_HPM) - 64'd1) << 3));

    logic [63:0]     mcycle;
    logic [63:0]     minstret;
    logic [63:0]     hpm_cnt [HPM_N];
    logic [7:0]      hpm_evt [HPM_N];
    logic [31:0]     mcountinhibit;

    logic [4:0]      num;
    logic            cnt_page;
    logic            cfg_page;
    logic            mapped;
    logic            ro;
    logic            wr_req;
    logic            we;
    logic            we_cnt;
    logic            we_cfg;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] wval;
    logic [HPM_N-1:0] hpm_hit;

    // Counter pages 0xBxx/0xCxx and the config page 0x320..0x33F share the
    // layout: addr[4:0] is the counter number (0 cycle, 2 instret, 3+ HPM),
    // addr[7] picks the high half on the counter pages.
    always_comb begin
        num      = addr[4:0];
        cnt_page = (addr[11:8] == 4'hB || addr[11:8] == 4'hC) && addr[6:5] == 2'b00;
        cfg_page = addr[11:5] == 7'b0011_001;
        mapped   = 1'b0;
        raw      = '0;
        if (cnt_page) begin
            if (num == 5'd0) begin
                mapped = 1'b1;
                raw    = addr[7] ? mcycle[63:32] : mcycle[31:0];
            end else if (num == 5'd2) begin
                mapped = 1'b1;
                raw    = addr[7] ? minstret[63:32] : minstret[31:0];
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (num == 5'(i + 3)) begin
                        mapped = 1'b1;
                        raw    = addr[7] ? hpm_cnt[i][63:32] : hpm_cnt[i][31:0];
                    end
                end
            end
        end else if (cfg_page) begin
            if (num == 5'd0) begin
                mapped = 1'b1;
                raw    = mcountinhibit;
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (num == 5'(i + 3)) begin
                        mapped = 1'b1;
                        raw    = XLEN'(hpm_evt[i]);
                    end
                end
            end
        end else begin
            case (addr)
                12'h301: begin mapped = 1'b1; raw = MISA;      end
                12'hF11: begin mapped = 1'b1; raw = MVENDORID; end
                12'hF12: begin mapped = 1'b1; raw = MARCHID;   end
                default: ;
            endcase
        end

        // 0xCxx..0xFxx and misa are read-only.
        ro      = addr[11:10] == 2'b11 || addr == 12'h301;
        wr_req  = csr_en && csr_op != 2'b00;
        illegal = csr_en && (!mapped || (wr_req && ro));
        rdata   = (mapped && !illegal) ? raw : '0;
        we      = wr_req && !illegal;
        we_cnt  = we && cnt_page && addr[11:8] == 4'hB;
        we_cfg  = we && cfg_page;

        case (csr_op)
            2'b01:   wval = wdata;
            2'b10:   wval = raw | wdata;
            2'b11:   wval = raw & ~wdata;
            default: wval = raw;
        endcase
    end

    // Selector value k picks events[k-1]; 0 never matches.
    always_comb begin
        hpm_hit = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int j = 0; j < NUM_EVENTS; j++) begin
                if (hpm_evt[i] == 8'(j + 1)) begin
                    hpm_hit[i] = events[j];
                end
            end
        end
    end

    // A write to either half of a counter wins over that counter's increment
    // for the cycle, with no carry into the other half. Inhibit bits are used
    // at their pre-edge value, so an inhibit write takes effect one edge later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcycle        <= '0;
            minstret      <= '0;
            mcountinhibit <= '0;
            for (int i = 0; i < HPM_N; i++) begin
                hpm_cnt[i] <= '0;
                hpm_evt[i] <= '0;
            end
        end else begin
            if (we_cnt && num == 5'd0) begin
                if (addr[7]) mcycle[63:32] <= wval;
                else         mcycle[31:0]  <= wval;
            end else if (!mcountinhibit[0]) begin
                mcycle <= mcycle + 64'd1;
            end

            if (we_cnt && num == 5'd2) begin
                if (addr[7]) minstret[63:32] <= wval;
                else         minstret[31:0]  <= wval;
            end else if (retire && !mcountinhibit[2]) begin
                minstret <= minstret + 64'd1;
            end

            for (int i = 0; i < NUM_HPM; i++) begin
                if (we_cnt && num == 5'(i + 3)) begin
                    if (addr[7]) hpm_cnt[i][63:32] <= wval;
                    else         hpm_cnt[i][31:0]  <= wval;
                end else if (hpm_hit[i] && !mcountinhibit[3 + i]) begin
                    hpm_cnt[i] <= hpm_cnt[i] + 64'd1;
                end
            end

            if (we_cfg && num == 5'd0) begin
                mcountinhibit <= wval & INH_MASK;
            end

            // Out-of-range selectors are stored as 0 (count nothing).
            for (int i = 0; i < NUM_HPM; i++) begin
                if (we_cfg && num == 5'(i + 3)) begin
                    hpm_evt[i] <= (wval != '0 && wval <= XLEN'(NUM_EVENTS)) ? wval[7:0] : 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_counters.sv
// tb/tb_csr_counters.sv - self-checking bench for csr_counters
module tb_csr_counters;

    localparam int NH = 4;
    localparam int NE = 8;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          csr_en  = 1'b0;
    logic [1:0]    csr_op  = 2'b00;
    logic [11:0]   addr    = 12'h000;
    logic [31:0]   wdata   = 32'h0;
    logic          retire  = 1'b0;
    logic [NE-1:0] events  = '0;
    logic [31:0]   rdata;
    logic          illegal;

    int tests = 0;
    int fails = 0;

    csr_counters dut (
        .clock   (clock),
        .reset_n (reset_n),
        .csr_en  (csr_en),
        .csr_op  (csr_op),
        .addr    (addr),
        .wdata   (wdata),
        .retire  (retire),
        .events  (events),
        .rdata   (rdata),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    // Model state indexed by counter number: 0 cycle, 2 instret, 3.. HPM.
    // The inhibit bit of counter c is bit c.
    longint unsigned m_cnt [32];
    int              m_sel [32];
    logic [31:0]     m_inh = 32'h0;

    function automatic bit exists(input int c);
        return c == 0 || c == 2 || (c >= 3 && c < 3 + NH);
    endfunction

    function automatic void lookup(input logic [11:0] a, output bit ok, output bit ro,
                                   output logic [31:0] v);
        ok = 0; ro = 0; v = 32'h0;
        if (a == 12'h301)      begin ok = 1; ro = 1; v = 32'h4000_0010; end
        else if (a == 12'hF11) begin ok = 1; ro = 1; v = 32'h6265_6b61; end
        else if (a == 12'hF12) begin ok = 1; ro = 1; v = 32'h0531_8008; end
        else if (a == 12'h320) begin ok = 1; v = m_inh; end
        else begin
            for (int c = 3; c < 3 + NH; c++)
                if (int'(a) == 'h320 + c) begin ok = 1; v = 32'(m_sel[c]); end
        end
        for (int c = 0; c < 32; c++) begin
            if (exists(c)) begin
                if (int'(a) == 'hB00 + c || int'(a) == 'hC00 + c) begin
                    ok = 1; v = m_cnt[c][31:0]; ro = (a >= 12'hC00);
                end
                if (int'(a) == 'hB80 + c || int'(a) == 'hC80 + c) begin
                    ok = 1; v = m_cnt[c][63:32]; ro = (a >= 12'hC00);
                end
            end
        end
    endfunction

    function automatic void expect_out(output logic [31:0] er, output logic ei);
        bit ok, ro;
        logic [31:0] v;
        lookup(addr, ok, ro, v);
        ei = csr_en && (!ok || (csr_op != 2'b00 && ro));
        er = (ok && !ei) ? v : 32'h0;
    endfunction

    function automatic void model_step();
        bit ok, ro, we, hit;
        logic [31:0] old, w;
        lookup(addr, ok, ro, old);
        we = csr_en && csr_op != 2'b00 && ok && !ro;
        case (csr_op)
            2'b01:   w = wdata;
            2'b10:   w = old | wdata;
            2'b11:   w = old & ~wdata;
            default: w = old;
        endcase
        for (int c = 0; c < 32; c++) begin
            if (exists(c)) begin
                hit = 0;
                if (c == 0) hit = 1;
                else if (c == 2) hit = retire;
                else if (m_sel[c] >= 1 && m_sel[c] <= NE) hit = events[m_sel[c] - 1];
                if (we && int'(addr) == 'hB00 + c)      m_cnt[c][31:0]  = w;
                else if (we && int'(addr) == 'hB80 + c) m_cnt[c][63:32] = w;
                else if (hit && !m_inh[c])              m_cnt[c] = m_cnt[c] + 1;
            end
        end
        if (we && addr == 12'h320) begin
            m_inh = 32'h0;
            for (int c = 0; c < 32; c++) if (exists(c)) m_inh[c] = w[c];
        end
        for (int c = 3; c < 3 + NH; c++)
            if (we && int'(addr) == 'h320 + c)
                m_sel[c] = (w >= 1 && w <= NE) ? int'(w) : 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 32; c++) begin
                m_cnt[c] = 0;
                m_sel[c] = 0;
            end
            m_inh = 32'h0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin : cmp
        logic [31:0] er;
        logic        ei;
        expect_out(er, ei);
        tests++;
        if (rdata !== er) begin
            fails++;
            $display("FAIL cycle_rdata addr=%h got %h want %h", addr, rdata, er);
        end
        tests++;
        if (illegal !== ei) begin
            fails++;
            $display("FAIL cycle_illegal addr=%h got %b want %b", addr, illegal, ei);
        end
    end

    task automatic drive(input logic en, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input logic ret, input logic [NE-1:0] ev);
        @(posedge clock);
        #1;
        csr_en = en; csr_op = op; addr = a; wdata = wd; retire = ret; events = ev;
    endtask

    task automatic peek(input string name, input logic [31:0] er, input logic ei);
        @(negedge clock);
        tests++;
        if (rdata !== er || illegal !== ei) begin
            fails++;
            $display("FAIL %s rdata=%h illegal=%b want rdata=%h illegal=%b",
                     name, rdata, illegal, er, ei);
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;

        // Reset state and combinational illegal during reset
        drive(0, 2'b00, 12'hB00, 0, 0, 0);     peek("reset_b00", 32'h0, 1'b0);
        drive(1, 2'b01, 12'hC00, 5, 0, 0);     peek("reset_illegal", 32'h0, 1'b1);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);
        reset_n = 1'b1;                        peek("release_b00", 32'h0, 1'b0);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);     peek("three_edges", 32'd3, 1'b0);
        drive(0, 2'b00, 12'hB80, 0, 0, 0);     peek("mcycleh_zero", 32'h0, 1'b0);

        // 64-bit wrap
        drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0);
        drive(1, 2'b01, 12'hB80, 32'hFFFF_FFFF, 0, 0);
        drive(0, 2'b00, 12'hB80, 0, 0, 0);     peek("wrap_hi_ones", 32'hFFFF_FFFF, 1'b0);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);     peek("wrap_lo_zero", 32'h0, 1'b0);
        drive(0, 2'b00, 12'hB80, 0, 0, 0);     peek("wrap_hi_zero", 32'h0, 1'b0);

        // Event selection and WARL selector
        drive(1, 2'b01, 12'h323, 2, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 2'b00, 12'hB03, 0, 0, 8'h02);
        drive(0, 2'b00, 12'hB03, 0, 0, 0);     peek("hpm3_five", 32'd5, 1'b0);
        drive(1, 2'b01, 12'h323, 9, 0, 0);
        drive(0, 2'b00, 12'h323, 0, 0, 0);     peek("evt_warl_zero", 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) drive(0, 2'b00, 12'hB03, 0, 0, 8'h02);
        drive(0, 2'b00, 12'hB03, 0, 0, 0);     peek("hpm3_stopped", 32'd5, 1'b0);

        // Inhibit, including one-edge latency in both directions
        drive(1, 2'b10, 12'h320, 4, 1, 0);
        for (int k = 0; k < 10; k++) drive(0, 2'b00, 12'hB02, 0, 1, 0);
        drive(0, 2'b00, 12'hB02, 0, 0, 0);     peek("instret_inhibited", 32'd1, 1'b0);
        drive(1, 2'b10, 12'h320, 2, 0, 0);
        drive(0, 2'b00, 12'h320, 0, 0, 0);     peek("inhibit_bit1_zero", 32'h4, 1'b0);
        drive(1, 2'b11, 12'h320, 4, 1, 0);
        for (int k = 0; k < 3; k++) drive(0, 2'b00, 12'hB02, 0, 1, 0);
        drive(0, 2'b00, 12'hB02, 0, 0, 0);     peek("instret_resumed", 32'd4, 1'b0);

        // Illegal accesses
        drive(1, 2'b01, 12'hC00, 5, 0, 0);     peek("ill_rw_c00", 32'h0, 1'b1);
        drive(1, 2'b10, 12'hF11, 1, 0, 0);     peek("ill_rs_f11", 32'h0, 1'b1);
        drive(1, 2'b01, 12'hB07, 5, 0, 0);     peek("ill_rw_b07", 32'h0, 1'b1);
        drive(1, 2'b00, 12'hB07, 0, 0, 0);     peek("ill_rd_b07", 32'h0, 1'b1);
        drive(1, 2'b00, 12'hF11, 0, 0, 0);     peek("vendorid", 32'h6265_6b61, 1'b0);
        drive(1, 2'b00, 12'hF12, 0, 0, 0);     peek("archid", 32'h0531_8008, 1'b0);
        drive(0, 2'b00, 12'h301, 0, 0, 0);     peek("misa", 32'h4000_0010, 1'b0);
        drive(0, 2'b00, 12'hB01, 0, 0, 0);     peek("unmapped_b01", 32'h0, 1'b0);
        drive(0, 2'b00, 12'hC02, 0, 0, 0);     peek("shadow_instret", 32'd4, 1'b0);

        // Half write with simultaneous retire
        drive(1, 2'b01, 12'hB82, 7, 0, 0);
        drive(1, 2'b11, 12'hB02, 32'hFFFF_FFFF, 1, 0);
        drive(0, 2'b00, 12'hB02, 0, 1, 0);     peek("half_lo_zero", 32'h0, 1'b0);
        drive(0, 2'b00, 12'hB82, 0, 0, 0);     peek("half_hi_kept", 32'd7, 1'b0);
        drive(0, 2'b00, 12'hB02, 0, 0, 0);     peek("half_resumed", 32'd1, 1'b0);

        // Reset during a write
        drive(1, 2'b01, 12'hB00, 32'h123, 0, 0);
        #2 reset_n = 1'b0;                     peek("reset_mid_write", 32'h0, 1'b0);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);
        reset_n = 1'b1;                        peek("reset_held", 32'h0, 1'b0);
        drive(0, 2'b00, 12'hB00, 0, 0, 0);     peek("reset_first_edge", 32'd1, 1'b0);

        drive(0, 2'b00, 12'h000, 0, 0, 0);
        @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_counters.md
# csr_counters

Parametrised successor of the machine CSR unit: holds the 64-bit `mcycle` and `minstret` counters, `NUM_HPM` programmable hardware performance counters with event selectors, and `mcountinhibit`. It also returns the read-only identification CSRs. It sits beside the decode/execute stage, serves CSRRW/CSRRS/CSRRC accesses with combinational read data, and flags illegal accesses to the trap logic.

## Interface
- `XLEN`, 32 — CSR data width; must be 32.
- `NUM_HPM`, 4 — number of `mhpmcounter3..` counters; legal range 0..29.
- `NUM_EVENTS`, 8 — width of the `events` bus; legal range 1..255.
- `MISA`, 32'h4000_0010 — value returned at 0x301.
- `MVENDORID`, "beka" — value returned at 0xF11.
- `MARCHID`, 32'h0531_8008 — value returned at 0xF12.

Ports:
- `clock  in  1` — single clock; all state updates on its rising edge.
- `reset_n  in  1` — asynchronous, active-low reset.
- `csr_en  in  1` — a CSR instruction is accessing `addr` this cycle.
- `csr_op  in  2` — 01 RW, 10 RS, 11 RC, 00 read-only.
- `addr  in  12` — CSR address.
- `wdata  in  XLEN` — operand for the write.
- `retire  in  1` — one instruction retired this cycle.
- `events  in  NUM_EVENTS` — one-cycle event pulses.
- `rdata  out  XLEN` — current value of the CSR at `addr`.
- `illegal  out  1` — access is illegal; no state changes.

## Operation
- **Address map**
  - `mcycle`/`mcycleh`: 0xB00 / 0xB80.
  - `minstret`/`minstreth`: 0xB02 / 0xB82.
  - `mhpmcounter(3+i)` and its high half: 0xB03+i / 0xB83+i.
  - `mhpmevent(3+i)`: 0x323+i.
  - `mcountinhibit`: 0x320.
  - User read-only shadows: 0xC00, 0xC02, 0xC03+i and their high halves at 0xC80, 0xC82, 0xC83+i.
  - Identification CSRs: 0x301, 0xF11, 0xF12.
- **Write value:** RW gives `wdata`; RS gives `old | wdata`; RC gives `old & ~wdata`. A write is performed when `csr_en` is high and `csr_op` is not 00.
- **Illegal:** `illegal` = `csr_en` and (the address is unmapped, or `i >= NUM_HPM` for an HPM address, or a write targets 0xCxx, 0xFxx or 0x301). When illegal, no state changes and `rdata` = 0.
- **Unmapped read:** `rdata` = 0 for any unmapped address, whether or not `csr_en` is high.
- **`mcountinhibit`:**
  - bit0 gates `mcycle`.
  - bit1 is hardwired 0.
  - bit2 gates `minstret`.
  - bit 3+i gates HPM counter i.
  - Bits for unimplemented counters read 0 and ignore writes.
- **`mhpmevent`:** a value k in 1..NUM_EVENTS selects `events[k-1]`. Writes of 0 or values greater than NUM_EVENTS store 0 (WARL), and 0 counts nothing.
- **Increment rules (all counters are 64-bit):**
  - `mcycle` increments by 1 every cycle when not inhibited.
  - `minstret` increments by 1 when `retire` is high and it is not inhibited.
  - HPM counter i increments by 1 when its selected event is high and it is not inhibited.
  - Every counter wraps from 2^64-1 to 0.
- **Write and increment together:** a write to either half replaces that half with the written value. The other half keeps its current value, and the increment is suppressed for that counter in that cycle. There is no carry into the untouched half.
- **Read value:** `rdata` is combinational from the current (pre-edge) state. The written value becomes visible in the cycle after the write.

## Timing
- **Reset:** while `reset_n` is low, all counters, `mcountinhibit` and every `mhpmevent` are 0 immediately. `illegal` then follows the inputs combinationally, and `rdata` for a counter address reads 0.
- **First increment:** the first rising edge with `reset_n` high increments `mcycle` to 1.
- **Reset during a write:** reset wins; the written value is lost.
- **Latency:**
  - Read: zero cycles.
  - Write: committed at the edge ending the access cycle.
  - Inhibit change: takes effect from the next edge, so the counter still increments at the edge where the inhibit bit is written.
- **Retire and event inputs:** sampled at the edge; each high cycle adds exactly 1.

## Test plan
- **Reset:** hold `reset_n` low, then release. Reading 0xB00 gives 0 before the first edge and 3 after 3 edges. Reading 0xB80 gives 0.
- **Wrap:** RW 0xFFFF_FFFF to 0xB00 and to 0xB80. The next cycle reads 0xFFFF_FFFF in both halves; after one more edge, both halves read 0.
- **Events:** write `mhpmevent3` = 2 (RW to 0x323) and pulse `events[1]` for 5 cycles → reading 0xB03 gives 5. Then write 9 with `NUM_EVENTS=8` → 0x323 reads back 0 and the counter stops.
- **Inhibit:** RS 0x320 with 0x4, then assert `retire` for 10 cycles → `minstret` is unchanged. RC 0x320 with 0x4, then 3 more retires → `minstret` is 3 higher. Also check that 0x320 bit1 always reads 0.
- **Illegal:** RW to 0xC00, RS to 0xF11, and any access to 0xB07 with `NUM_HPM=4` → `illegal`=1, `rdata`=0, no counter write. A read-only access (`csr_op`=00) to 0xF11 → `rdata`="beka" and `illegal`=0.
- **Half write:** RC 0xB02 with 0xFFFF_FFFF while `retire`=1 → the low half reads 0 the next cycle and the high half is unchanged. Counting resumes on the following edge.
